// File: rtl/regn_pkg.sv
// regn_pkg: shared limits and helpers for the regn_pipe register pipeline.
//   REGN_MAX_DEPTH : largest supported number of stages
//   REGN_MAX_N     : largest supported data width
//   occ_width()    : bit width needed to count 0..depth valid items
package regn_pkg;

   localparam int REGN_MAX_DEPTH = 8;
   localparam int REGN_MAX_N     = 64;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/regn_stage.sv
// regn_stage: one pipeline slot, a valid flag plus N-bit data.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   load       : take v_in/d_in this edge (data only written when v_in=1)
//   clear      : invalidate the slot, data is kept
//   v_in, d_in : incoming valid/data from the previous slot or the input
//   v, d       : registered valid/data
module regn_stage #(
   parameter int             N       = 32,
   parameter logic [N-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic         v_in,
   input  logic [N-1:0] d_in,
   output logic         v,
   output logic [N-1:0] d
);

   always_ff @(posedge clk) begin
      if (rst) begin
         v <= 1'b0;
         d <= RST_VAL;
      end else if (clear) begin
         v <= 1'b0;
      end else if (load) begin
         v <= v_in;
         // bubbles move through without disturbing the held data
         if (v_in) d <= d_in;
      end
   end

endmodule

// File: rtl/regn_pipe.sv
// regn_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse,
// synchronous flush and a registered occupancy counter.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : invalidate all stages; blocks transfers this cycle
//   in_valid, in_ready  : upstream handshake, di is the input data
//   out_valid, out_ready: downstream handshake, dout is the last stage data
//                         (named dout because "do" is a reserved word)
//   occupancy           : number of valid items held
module regn_pipe
   import regn_pkg::*;
#(
   parameter int           N       = 32,
   parameter int           DEPTH   = 2,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N-1:0]                  di,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N-1:0]                  dout,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OW = occ_width(DEPTH);

   if (N < 1 || N > REGN_MAX_N) begin : g_bad_n
      $error("regn_pipe: N=%0d outside 1..%0d", N, REGN_MAX_N);
   end
   if (DEPTH < 1 || DEPTH > REGN_MAX_DEPTH) begin : g_bad_depth
      $error("regn_pipe: DEPTH=%0d outside 1..%0d", DEPTH, REGN_MAX_DEPTH);
   end

   logic [DEPTH:0]   rdy;
   logic [DEPTH-1:0] v;
   logic [N-1:0]     d [DEPTH];
   logic             in_xfer;
   logic             out_xfer;

   assign rdy[DEPTH] = out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic         v_in;
      logic [N-1:0] d_in;

      // an empty slot always accepts, so bubbles collapse under a stall
      assign rdy[i] = !v[i] || rdy[i+1];

      if (i == 0) begin : g_first
         assign v_in = in_valid;
         assign d_in = di;
      end else begin : g_next
         assign v_in = v[i-1];
         assign d_in = d[i-1];
      end

      regn_stage #(
         .N       (N),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .load  (rdy[i] && !flush),
         .clear (flush),
         .v_in  (v_in),
         .d_in  (d_in),
         .v     (v[i]),
         .d     (d[i])
      );
   end

   assign in_ready  = rdy[0] && !flush && !rst;
   assign out_valid = v[DEPTH-1] && !flush;
   assign dout      = d[DEPTH-1];

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         occupancy <= '0;
      end else if (in_xfer && !out_xfer) begin
         occupancy <= occupancy + OW'(1);
      end else if (out_xfer && !in_xfer) begin
         occupancy <= occupancy - OW'(1);
      end
   end

endmodule

// File: tb/tb_regn_pipe.sv
module tb_regn_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] di = '0;

   logic        ir_a  [1:8];
   logic        ov_a  [1:8];
   logic [31:0] do_a  [1:8];
   logic [3:0]  occ_a [1:8];

   int n_vec = 0;
   int n_err = 0;

   // reference model: ordered list of items held, per depth
   logic [31:0] mq    [1:8][0:9];
   int          mcnt  [1:8];
   int          stall [1:8];

   always #5 clk = ~clk;

   for (genvar g = 1; g <= 8; g++) begin : g_dut
      localparam int OW = $clog2(g + 1);
      logic [OW-1:0] occ_w;
      logic          ir_w;
      logic          ov_w;
      logic [31:0]   do_w;

      regn_pipe #(
         .N       (32),
         .DEPTH   (g),
         .RST_VAL (32'h0)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .in_valid  (in_valid),
         .in_ready  (ir_w),
         .di        (di),
         .out_valid (ov_w),
         .out_ready (out_ready),
         .dout      (do_w),
         .occupancy (occ_w)
      );

      assign ir_a[g]  = ir_w;
      assign ov_a[g]  = ov_w;
      assign do_a[g]  = do_w;
      assign occ_a[g] = 4'(occ_w);
   end

   // apply one cycle of inputs after the falling edge; outputs settle by #1
   task automatic cyc(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic o);
      @(negedge clk);
      rst = r; flush = f; in_valid = iv; di = d; out_ready = o;
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         cyc(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
         for (int d = 1; d <= 8; d++) begin
            n_vec++;
            if (ir_a[d] !== 1'b0) begin
               n_err++;
               $display("FAIL reset_in_ready depth=%0d got=%b exp=0", d, ir_a[d]);
            end
         end
      end
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int d = 1; d <= 8; d++) begin
         n_vec++;
         if (ov_a[d] !== 1'b0 || do_a[d] !== 32'h0 || occ_a[d] !== 4'd0 || ir_a[d] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state depth=%0d got ov=%b do=%h occ=%0d ir=%b exp ov=0 do=0 occ=0 ir=1",
                     d, ov_a[d], do_a[d], occ_a[d], ir_a[d]);
         end
      end
   endtask

   task automatic test_stream();
      logic        e_ov  [6] = '{0, 0, 1, 1, 1, 0};
      logic [31:0] e_do  [6] = '{0, 0, 1, 2, 3, 0};
      logic [3:0]  e_occ [6] = '{0, 1, 2, 2, 1, 0};
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 1'b0, k < 3, 32'(k + 1), 1'b1);
         n_vec++;
         if (ov_a[2] !== e_ov[k] || occ_a[2] !== e_occ[k] ||
             (e_ov[k] && do_a[2] !== e_do[k]) || (k < 3 && ir_a[2] !== 1'b1)) begin
            n_err++;
            $display("FAIL stream cyc=%0d got ov=%b do=%0d occ=%0d ir=%b exp ov=%b do=%0d occ=%0d",
                     k, ov_a[2], do_a[2], occ_a[2], ir_a[2], e_ov[k], e_do[k], e_occ[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int nxt = 1;
      int got = 0;
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 32'(nxt), 1'b0);
         n_vec++;
         if (ir_a[3] !== (k < 3) || occ_a[3] !== 4'((k < 3) ? k : 3)) begin
            n_err++;
            $display("FAIL bp_fill cyc=%0d got ir=%b occ=%0d exp ir=%b occ=%0d",
                     k, ir_a[3], occ_a[3], k < 3, (k < 3) ? k : 3);
         end
         if (ir_a[3]) nxt++;
      end
      for (int c = 0; c < 20 && got < 5; c++) begin
         cyc(1'b0, 1'b0, nxt <= 5, 32'(nxt), 1'b1);
         if (c < 2) begin
            n_vec++;
            if (occ_a[3] !== 4'd3 || ir_a[3] !== 1'b1) begin
               n_err++;
               $display("FAIL bp_full_both cyc=%0d got occ=%0d ir=%b exp occ=3 ir=1",
                        c, occ_a[3], ir_a[3]);
            end
         end
         if (ov_a[3]) begin
            n_vec++;
            if (do_a[3] !== 32'(got + 1)) begin
               n_err++;
               $display("FAIL bp_order got=%0d exp=%0d", do_a[3], got + 1);
            end
            got++;
         end
         if (ir_a[3] && in_valid) nxt++;
      end
      n_vec++;
      if (got != 5) begin
         n_err++;
         $display("FAIL bp_drain_count got=%0d exp=5", got);
      end
   endtask

   task automatic test_bubble();
      logic pat [6] = '{1, 0, 0, 1, 1, 1};
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 1'b0, pat[k], 32'(k + 20), 1'b0);
         if (pat[k]) begin
            n_vec++;
            if (ir_a[4] !== 1'b1) begin
               n_err++;
               $display("FAIL bubble_accept cyc=%0d got ir=%b exp=1", k, ir_a[4]);
            end
         end
      end
      cyc(1'b0, 1'b0, 1'b1, 32'd99, 1'b0);
      n_vec++;
      if (occ_a[4] !== 4'd4 || ir_a[4] !== 1'b0 || do_a[4] !== 32'd20) begin
         n_err++;
         $display("FAIL bubble_full got occ=%0d ir=%b do=%0d exp occ=4 ir=0 do=20",
                  occ_a[4], ir_a[4], do_a[4]);
      end
   endtask

   task automatic test_flush();
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 32'(10 + k), 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 32'd99, 1'b1);
      n_vec++;
      if (ov_a[3] !== 1'b0 || ir_a[3] !== 1'b0 || occ_a[3] !== 4'd3) begin
         n_err++;
         $display("FAIL flush_comb got ov=%b ir=%b occ=%0d exp ov=0 ir=0 occ=3",
                  ov_a[3], ir_a[3], occ_a[3]);
      end
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      n_vec++;
      if (occ_a[3] !== 4'd0 || ov_a[3] !== 1'b0 || do_a[3] !== 32'd10) begin
         n_err++;
         $display("FAIL flush_after got occ=%0d ov=%b do=%0d exp occ=0 ov=0 do=10",
                  occ_a[3], ov_a[3], do_a[3]);
      end
   endtask

   task automatic test_random();
      logic r, f, iv, o, exp_ir;
      logic [31:0] dv;
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int d = 1; d <= 8; d++) begin
         mcnt[d] = 0;
         stall[d] = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         r  = ($urandom_range(0, 299) == 0);
         f  = ($urandom_range(0, 79) == 0);
         iv = ($urandom_range(0, 3) != 0);
         o  = ($urandom_range(0, 9) < 6);
         dv = $urandom();
         cyc(r, f, iv, dv, o);
         for (int d = 1; d <= 8; d++) begin
            // only a completely full pipe with a stalled consumer refuses input
            exp_ir = !r && !f && !(mcnt[d] == d && !o);
            n_vec++;
            if (ir_a[d] !== exp_ir || occ_a[d] !== 4'(mcnt[d])) begin
               n_err++;
               $display("FAIL rand_ready_occ cyc=%0d depth=%0d got ir=%b occ=%0d exp ir=%b occ=%0d",
                        c, d, ir_a[d], occ_a[d], exp_ir, mcnt[d]);
            end
            if (f) begin
               n_vec++;
               if (ov_a[d] !== 1'b0) begin
                  n_err++;
                  $display("FAIL rand_flush_ov cyc=%0d depth=%0d got=%b exp=0", c, d, ov_a[d]);
               end
            end
            if (ov_a[d] === 1'b1) begin
               n_vec++;
               if (mcnt[d] == 0 || do_a[d] !== mq[d][0]) begin
                  n_err++;
                  $display("FAIL rand_order cyc=%0d depth=%0d got=%h exp=%h held=%0d",
                           c, d, do_a[d], mq[d][0], mcnt[d]);
               end
            end
            // the oldest item reaches the output within DEPTH-1 cycles
            if (mcnt[d] > 0 && !f && !r) begin
               stall[d] = (ov_a[d] === 1'b1) ? 0 : stall[d] + 1;
               n_vec++;
               if (stall[d] > d) begin
                  n_err++;
                  $display("FAIL rand_latency cyc=%0d depth=%0d got wait=%0d exp<=%0d",
                           c, d, stall[d], d);
                  stall[d] = 0;
               end
            end else begin
               stall[d] = 0;
            end
            if (r || f) begin
               mcnt[d] = 0;
            end else begin
               if (ov_a[d] === 1'b1 && o && mcnt[d] > 0) begin
                  for (int j = 0; j < mcnt[d] - 1; j++) mq[d][j] = mq[d][j+1];
                  mcnt[d]--;
               end
               if (exp_ir && iv && mcnt[d] < 10) begin
                  mq[d][mcnt[d]] = dv;
                  mcnt[d]++;
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble();
      test_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regn_pipe.md
REGN_PIPE -- requirements
Module: regn_pipe

Interface
REQ-001 Parameter N, default 32: data width in bits, legal 1..64.
REQ-002 Parameter DEPTH, default 2: number of register stages, legal 1..8.
REQ-003 Parameter RST_VAL, default 0: N-bit value loaded into every data stage on reset.
REQ-004 The block SHALL have one clock, clk, and the reset is synchronous and active-high, rst.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 flush  in  1  synchronous pipeline invalidate, active-high.
REQ-008 in_valid  in  1  upstream presents di.
REQ-009 in_ready  out  1  block accepts di this cycle.
REQ-010 di  in  N  input data.
REQ-011 out_valid  out  1  do holds a valid item.
REQ-012 out_ready  in  1  downstream accepts do this cycle.
REQ-013 do  out  N  output data, taken from the last stage.
REQ-014 occupancy  out  $clog2(DEPTH+1)  number of valid items held.

Function
REQ-015 Each stage i (0..DEPTH-1) SHALL hold valid bit v[i] and data d[i]; stage 0 is the input and stage DEPTH-1 drives do/out_valid.
REQ-016 The ready chain SHALL be rdy[DEPTH]=out_ready and rdy[i]=!v[i] || rdy[i+1]; in_ready=rdy[0] && !flush.
REQ-017 On a clk edge with rdy[i]=1, stage i SHALL load v[i-1]/d[i-1] (stage 0 loads in_valid/di); with rdy[i]=0 it SHALL hold.
REQ-018 d[i] SHALL be written only when the incoming valid is 1; bubbles leave data unchanged.
REQ-019 Transfers: input when in_valid && in_ready; output when out_valid && out_ready.
REQ-020 Latency, empty pipe and out_ready=1: an item accepted on edge t SHALL appear on do with out_valid=1 immediately after edge t+DEPTH-1.
REQ-021 Throughput SHALL be one item per cycle while out_ready=1.
REQ-022 Bubbles SHALL collapse: an empty stage accepts even when the downstream stage is stalled.
REQ-023 Full is occupancy==DEPTH with out_ready=0; then in_ready=0 and all stages hold.
REQ-024 Full with out_ready=1: a simultaneous input and output SHALL both complete, and occupancy SHALL stay DEPTH.
REQ-025 Empty: out_valid=0; do shows the last valid data or RST_VAL.
REQ-026 flush=1: in_ready=0 and out_valid=0 combinationally; no transfer completes; all v[i] SHALL clear at the edge; d[i] holds; occupancy becomes 0.
REQ-027 occupancy SHALL be a registered counter: +1 on input transfer, -1 on output transfer, unchanged on both; it SHALL always equal popcount(v).
REQ-028 No item SHALL be duplicated, dropped or reordered, except items invalidated by flush.

Reset
REQ-029 On rst=1 at an edge: all v[i]=0, all d[i]=RST_VAL, occupancy=0; after reset, out_valid=0 and do=RST_VAL.
REQ-030 rst SHALL take priority over flush and over all transfers; reset mid-stream discards every held item.
REQ-031 While rst=1, in_ready SHALL be 0.

Structure
REQ-032 Package regn_pkg SHALL hold the constants REGN_MAX_DEPTH=8 and REGN_MAX_N=64 and the occupancy width function.
REQ-033 Sub-module regn_stage (one valid bit plus N-bit data, load/clear inputs) SHALL be instantiated DEPTH times by a generate loop.
REQ-034 Parameter legality SHALL be checked at elaboration.

Verification
REQ-035 Reset: assert rst for 2 cycles with in_valid=1 and di=32'hDEAD_BEEF -> out_valid=0, do=0, occupancy=0, in_ready=0 during reset.
REQ-036 Streaming, DEPTH=2, out_ready=1: push 1,2,3 on consecutive edges -> do=1,2,3 on consecutive cycles, with the first one edge after acceptance; occupancy peaks at 2.
REQ-037 Backpressure, DEPTH=3, out_ready=0: push 5 items -> first 3 accepted, in_ready=0, occupancy=3; release out_ready -> output order 1..5 with no loss.
REQ-038 Bubble collapse, DEPTH=4, out_ready=0: push one item, idle 2 cycles, push 3 more -> all accepted, occupancy=4.
REQ-039 Flush, DEPTH=3 full: assert flush with in_valid=1 and out_ready=1 -> out_valid=0, in_ready=0, no transfers; next cycle occupancy=0 and do unchanged.
REQ-040 Random stimulus, all DEPTH 1..8: scoreboard ordering and the occupancy==popcount invariant for 10k cycles with random in_valid, out_ready and rare flush/rst.
